// File: rtl/srb_deserializer_if.sv
// Bundle for the SRB deserializer: serial input channel from the chain and the
// word output slot (valid/ready). The master modport is the deserializer side.
interface srb_deserializer_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             sin_bit;
  logic             sin_en;
  logic             sin_stall;
  logic [WIDTH-1:0] word_data;
  logic [CW-1:0]    word_popcnt;
  logic             word_valid;
  logic             word_ready;

  modport master (
    input  sin_bit, sin_en, word_ready,
    output sin_stall, word_data, word_popcnt, word_valid
  );

  modport slave (
    output sin_bit, sin_en, word_ready,
    input  sin_stall, word_data, word_popcnt, word_valid
  );
endinterface

// File: rtl/srb_deserializer.sv
// Receive end of the SRB shift chain: packs serial bits into WIDTH-bit words,
// each emitted with its popcount through a one-deep valid/ready output slot.
module srb_deserializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  srb_deserializer_if.master  bus,
  output logic                busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] sr_q, sr_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [CW-1:0]    pop_q, pop_nxt;
  logic             valid_q, valid_nxt;
  logic [WIDTH-1:0] shifted;
  logic             acc;
  logic             free;
  logic             last_bit;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  always_comb begin
    if (MSB_FIRST) shifted = {sr_q[WIDTH-2:0], bus.sin_bit};
    else           shifted = {bus.sin_bit, sr_q[WIDTH-1:1]};
  end

  assign acc      = bus.sin_en & (state_q == COLLECT);
  assign free     = ~valid_q | bus.word_ready;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state_q;
    sr_nxt    = sr_q;
    cnt_nxt   = cnt_q;
    data_nxt  = data_q;
    pop_nxt   = pop_q;
    valid_nxt = valid_q;

    if (clear) begin
      // Collection side aborts; the output slot still honours a handshake.
      sr_nxt    = '0;
      cnt_nxt   = '0;
      state_nxt = COLLECT;
      if (valid_q && bus.word_ready) valid_nxt = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (valid_q && bus.word_ready) valid_nxt = 1'b0;
          if (acc) begin
            if (last_bit) begin
              cnt_nxt = '0;
              if (free) begin
                data_nxt  = shifted;
                pop_nxt   = popcount(shifted);
                valid_nxt = 1'b1;
                sr_nxt    = '0;
              end else begin
                sr_nxt    = shifted;
                state_nxt = FULL;
              end
            end else begin
              sr_nxt  = shifted;
              cnt_nxt = cnt_q + 1'b1;
            end
          end
        end
        FULL: begin
          // The slot is always occupied here, so ready alone is the handshake.
          if (bus.word_ready) begin
            data_nxt  = sr_q;
            pop_nxt   = popcount(sr_q);
            valid_nxt = 1'b1;
            sr_nxt    = '0;
            state_nxt = COLLECT;
          end
        end
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      pop_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sr_q    <= sr_nxt;
      cnt_q   <= cnt_nxt;
      data_q  <= data_nxt;
      pop_q   <= pop_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign bus.sin_stall   = (state_q == FULL);
  assign bus.word_data   = data_q;
  assign bus.word_popcnt = pop_q;
  assign bus.word_valid  = valid_q;
  assign busy            = (cnt_q != '0) | (state_q == FULL);
endmodule

// File: tb/tb_srb_deserializer.sv
// Scoreboard bench for srb_deserializer: DUT A (MSB first) and DUT B (LSB
// first), both 8-bit; a negedge monitor checks every completed handshake.
module tb_srb_deserializer;
  logic clk;
  logic rst;
  logic clear;
  logic busy_a, busy_b;

  srb_deserializer_if #(.WIDTH(8)) a_if ();
  srb_deserializer_if #(.WIDTH(8)) b_if ();

  srb_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .bus(a_if.master), .busy(busy_a)
  );
  srb_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .bus(b_if.master), .busy(busy_b)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] p;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int b_words = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare each word at the edge where it is handed over.
  always @(negedge clk) begin
    if (rst && a_if.word_valid && a_if.word_ready) begin
      if (qa.size() == 0) begin
        check("a_unexpected_word", {24'd0, a_if.word_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_word_data", {24'd0, a_if.word_data}, {24'd0, e.d});
        check("a_word_popcnt", {28'd0, a_if.word_popcnt}, {28'd0, e.p});
      end
    end
    if (rst && b_if.word_valid && b_if.word_ready) begin
      b_words++;
      if (qb.size() == 0) begin
        check("b_unexpected_word", {24'd0, b_if.word_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_word_data", {24'd0, b_if.word_data}, {24'd0, e.d});
        check("b_word_popcnt", {28'd0, b_if.word_popcnt}, {28'd0, e.p});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit and hold it until an edge accepts it (stall low before the edge).
  task automatic send_bit(input bit sel_b, input logic b);
    bit accepted;
    int n;
    n = 0;
    if (sel_b) begin b_if.sin_en = 1'b1; b_if.sin_bit = b; end
    else       begin a_if.sin_en = 1'b1; a_if.sin_bit = b; end
    forever begin
      accepted = sel_b ? !b_if.sin_stall : !a_if.sin_stall;
      tick();
      if (accepted) break;
      n++;
      if (n > 50) begin
        check("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end
    a_if.sin_en = 1'b0;
    b_if.sin_en = 1'b0;
  endtask

  task automatic send_word(input bit sel_b, input logic [7:0] v, input int max_gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(sel_b, sel_b ? v[i] : v[7-i]);
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        for (int k = 0; k < g; k++) tick();
      end
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic [3:0] p);
    exp_t e;
    e.d = d;
    e.p = p;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] d, input logic [3:0] p);
    exp_t e;
    e.d = d;
    e.p = p;
    qb.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    clear = 1'b0;
    a_if.sin_bit = 1'b0; a_if.sin_en = 1'b0; a_if.word_ready = 1'b1;
    b_if.sin_bit = 1'b0; b_if.sin_en = 1'b0; b_if.word_ready = 1'b1;
    tick(); tick();
    check("rst_valid", {31'd0, a_if.word_valid}, 32'd0);
    check("rst_data", {24'd0, a_if.word_data}, 32'd0);
    check("rst_popcnt", {28'd0, a_if.word_popcnt}, 32'd0);
    check("rst_stall", {31'd0, a_if.sin_stall}, 32'd0);
    check("rst_busy", {30'd0, busy_a, busy_b}, 32'd0);
    rst = 1'b1;
    tick();

    // 1: basic word, latency of one cycle after the last bit
    push_a(8'hB2, 4'd4);
    for (int i = 0; i < 7; i++) send_bit(1'b0, (8'hB2 >> (7 - i)) & 1'b1);
    check("t1_not_early", {31'd0, a_if.word_valid}, 32'd0);
    send_bit(1'b0, 1'b0);
    check("t1_valid", {31'd0, a_if.word_valid}, 32'd1);
    check("t1_data", {24'd0, a_if.word_data}, 32'hB2);
    check("t1_popcnt", {28'd0, a_if.word_popcnt}, 32'd4);
    tick();
    check("t1_drained", {31'd0, a_if.word_valid}, 32'd0);

    // 2: back-pressure into FULL, then drain
    a_if.word_ready = 1'b0;
    push_a(8'hB2, 4'd4);
    send_word(1'b0, 8'hB2, 0);
    push_a(8'hFF, 4'd8);
    send_word(1'b0, 8'hFF, 0);
    check("t2_stall", {31'd0, a_if.sin_stall}, 32'd1);
    check("t2_busy_full", {31'd0, busy_a}, 32'd1);
    a_if.sin_en = 1'b1;
    a_if.sin_bit = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t2_stall_held", {31'd0, a_if.sin_stall}, 32'd1);
    check("t2_data_stable", {24'd0, a_if.word_data}, 32'hB2);
    a_if.word_ready = 1'b1;
    push_a(8'h3C, 4'd4);
    send_word(1'b0, 8'h3C, 0);
    tick();
    check("t2_all_drained", qa.size(), 32'd0);

    // 3: same data with random gaps in sin_en
    push_a(8'hB2, 4'd4);
    for (int i = 0; i < 4; i++) send_bit(1'b0, (8'hB2 >> (7 - i)) & 1'b1);
    check("t3_busy_mid", {31'd0, busy_a}, 32'd1);
    for (int i = 4; i < 8; i++) begin
      send_bit(1'b0, (8'hB2 >> (7 - i)) & 1'b1);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
    end
    tick();
    check("t3_busy_idle", {31'd0, busy_a}, 32'd0);
    check("t3_drained", {31'd0, a_if.word_valid}, 32'd0);

    // 4a: clear discards partial word and the bit presented with it
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    clear = 1'b1;
    a_if.sin_en = 1'b1;
    a_if.sin_bit = 1'b1;
    tick();
    clear = 1'b0;
    a_if.sin_en = 1'b0;
    check("t4_busy_cleared", {31'd0, busy_a}, 32'd0);
    push_a(8'h0F, 4'd4);
    send_word(1'b0, 8'h0F, 0);
    tick();

    // 4b: clear while FULL drops the pending word, slot keeps its word
    a_if.word_ready = 1'b0;
    push_a(8'hA5, 4'd4);
    send_word(1'b0, 8'hA5, 0);
    send_word(1'b0, 8'h7E, 0);
    check("t4_full", {31'd0, a_if.sin_stall}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4_unstall", {31'd0, a_if.sin_stall}, 32'd0);
    check("t4_busy", {31'd0, busy_a}, 32'd0);
    check("t4_slot_kept", {23'd0, a_if.word_valid, a_if.word_data}, {23'd0, 1'b1, 8'hA5});
    a_if.word_ready = 1'b1;
    tick();
    push_a(8'h81, 4'd2);
    send_word(1'b0, 8'h81, 0);
    tick();

    // 5: reset mid-word and with a word held in the slot
    a_if.word_ready = 1'b0;
    send_word(1'b0, 8'h55, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    check("t5_pre_valid", {31'd0, a_if.word_valid}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t5_valid", {31'd0, a_if.word_valid}, 32'd0);
    check("t5_data", {24'd0, a_if.word_data}, 32'd0);
    check("t5_popcnt", {28'd0, a_if.word_popcnt}, 32'd0);
    check("t5_stall_busy", {30'd0, a_if.sin_stall, busy_a}, 32'd0);
    a_if.word_ready = 1'b1;
    push_a(8'h96, 4'd4);
    send_word(1'b0, 8'h96, 0);
    tick();

    // 6: LSB-first DUT, then four back-to-back words
    push_b(8'h01, 4'd1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, (i == 0) ? 1'b1 : 1'b0);
    check("t6_data", {24'd0, b_if.word_data}, 32'h01);
    check("t6_popcnt", {28'd0, b_if.word_popcnt}, 32'd1);
    tick();
    begin
      int c0, w0;
      logic [7:0] vals [4];
      vals[0] = 8'hC3; vals[1] = 8'h10; vals[2] = 8'hFE; vals[3] = 8'h6A;
      push_b(8'hC3, 4'd4);
      push_b(8'h10, 4'd1);
      push_b(8'hFE, 4'd7);
      push_b(8'h6A, 4'd4);
      c0 = cyc;
      w0 = b_words;
      for (int w = 0; w < 4; w++) send_word(1'b1, vals[w], 0);
      check("t6_no_idle", cyc - c0, 32'd32);
      tick();
      check("t6_four_valids", b_words - w0, 32'd4);
    end

    for (int i = 0; i < 4; i++) tick();
    check("a_queue_empty", qa.size(), 32'd0);
    check("b_queue_empty", qb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
